// File: rtl/rtc24_to_12_clock.sv
// Running time-of-day clock with a 24-hour register core and 12-hour presentation.
// The prescaler divides enabled clocks down to one-second advances, and a
// synchronous load replaces the time when its fields are in range.
//
// Load interface: `load` is a single-cycle request with no ready/back-pressure.
// The request is consumed on the same rising edge that samples it. Its outcome
// is visible in the following cycle:
//   - accepted: the new time is shown with load_err=0;
//   - rejected: load_err=1 and the time is unchanged.
// A load always wins over a tick that would have happened on the same edge.
module rtc24_to_12_clock #(
  parameter int unsigned SEC_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] ld_h24,
  input  logic [5:0] ld_m,
  input  logic [5:0] ld_s,
  output logic [3:0] h12,
  output logic       pm,
  output logic [5:0] m,
  output logic [5:0] s,
  output logic       sec_pulse,
  output logic       load_err
);

  // Terminal prescaler count; SEC_DIV is limited to 16 bits.
  localparam logic [15:0] PRESC_LAST = 16'(SEC_DIV - 1);

  // Registered state.
  logic [4:0]  h_q;
  logic [5:0]  m_q;
  logic [5:0]  s_q;
  logic [15:0] presc_q;
  logic        sec_pulse_q;
  logic        load_err_q;

  // Combinational helpers.
  logic        load_valid;
  logic        presc_wrap;
  logic [4:0]  h_inc;
  logic [5:0]  m_inc;
  logic [5:0]  s_inc;

  // A load is accepted only when every field lies inside its time-of-day range,
  // so the registers can never hold an illegal time.
  assign load_valid = (ld_h24 <= 5'd23) && (ld_m <= 6'd59) && (ld_s <= 6'd59);

  // The prescaler sits on its last count: the next enabled edge advances time.
  assign presc_wrap = (presc_q == PRESC_LAST);

  // One-second advance with the seconds -> minutes -> hours carry chain.
  always_comb begin
    s_inc = s_q;
    m_inc = m_q;
    h_inc = h_q;
    if (s_q == 6'd59) begin
      s_inc = 6'd0;
      if (m_q == 6'd59) begin
        m_inc = 6'd0;
        if (h_q == 5'd23) begin
          h_inc = 5'd0;
        end else begin
          h_inc = h_q + 5'd1;
        end
      end else begin
        m_inc = m_q + 6'd1;
      end
    end else begin
      s_inc = s_q + 6'd1;
    end
  end

  // Time, prescaler and status pulses; load beats tick, tick beats hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= 5'd0;
      m_q         <= 6'd0;
      s_q         <= 6'd0;
      presc_q     <= 16'd0;
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else if (load) begin
      // The would-be tick on this edge is dropped and no second pulse is raised.
      sec_pulse_q <= 1'b0;
      if (load_valid) begin
        h_q        <= ld_h24;
        m_q        <= ld_m;
        s_q        <= ld_s;
        presc_q    <= 16'd0;
        load_err_q <= 1'b0;
      end else begin
        // Rejected: time and prescaler keep their values.
        load_err_q <= 1'b1;
      end
    end else if (run) begin
      load_err_q <= 1'b0;
      if (presc_wrap) begin
        presc_q     <= 16'd0;
        h_q         <= h_inc;
        m_q         <= m_inc;
        s_q         <= s_inc;
        sec_pulse_q <= 1'b1;
      end else begin
        presc_q     <= presc_q + 16'd1;
        sec_pulse_q <= 1'b0;
      end
    end else begin
      // Frozen: prescaler and time hold, pulses drop.
      sec_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end
  end

  // 24-hour to 12-hour decode straight from the registers (no added latency).
  always_comb begin
    h12 = 4'd12;
    pm  = 1'b0;
    if (h_q == 5'd0) begin
      h12 = 4'd12;
      pm  = 1'b0;
    end else if (h_q < 5'd12) begin
      h12 = h_q[3:0];
      pm  = 1'b0;
    end else if (h_q == 5'd12) begin
      h12 = 4'd12;
      pm  = 1'b1;
    end else begin
      // h_q is 13..23 here, so the difference is 1..11 and fits in 4 bits.
      h12 = 4'(h_q - 5'd12);
      pm  = 1'b1;
    end
  end

  assign m         = m_q;
  assign s         = s_q;
  assign sec_pulse = sec_pulse_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc24_to_12_clock.sv
// Bench for rtc24_to_12_clock: decode table, hand-written corner sequences,
// and a randomized sweep compared against a seconds-of-day reference model.
module tb_rtc24_to_12_clock;

  localparam int unsigned SEC_DIV = 4;
  localparam int DAY_SECS = 24 * 3600;

  // Clock / reset.
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [4:0] ld_h24 = 5'd0;
  logic [5:0] ld_m = 6'd0;
  logic [5:0] ld_s = 6'd0;
  logic [3:0] h12;
  logic       pm;
  logic [5:0] m;
  logic [5:0] s;
  logic       sec_pulse;
  logic       load_err;

  always #5 clk = ~clk;

  rtc24_to_12_clock #(.SEC_DIV(SEC_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .ld_h24(ld_h24), .ld_m(ld_m), .ld_s(ld_s),
    .h12(h12), .pm(pm), .m(m), .s(s),
    .sec_pulse(sec_pulse), .load_err(load_err)
  );

  // Observed outputs as one word: {h12, pm, m, s, sec_pulse, load_err}.
  logic [18:0] dut_out;
  assign dut_out = {h12, pm, m, s, sec_pulse, load_err};

  int checks = 0;
  int failures = 0;

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int   mdl_t = 0;
  int   mdl_p = 0;
  logic mdl_pulse = 1'b0;
  logic mdl_err = 1'b0;

  function automatic logic [18:0] pk(input int hh12, input int ispm, input int mm,
                                     input int ss, input int p, input int e);
    return {4'(hh12), 1'(ispm), 6'(mm), 6'(ss), 1'(p), 1'(e)};
  endfunction

  function automatic logic [18:0] model_out();
    int h24;
    int hmod;
    h24  = mdl_t / 3600;
    hmod = h24 % 12;
    return pk((hmod == 0) ? 12 : hmod, (h24 >= 12) ? 1 : 0,
              (mdl_t / 60) % 60, mdl_t % 60, int'(mdl_pulse), int'(mdl_err));
  endfunction

  task automatic model_reset();
    mdl_t = 0;
    mdl_p = 0;
    mdl_pulse = 1'b0;
    mdl_err = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic l, input int hh, input int mm, input int ss);
    if (l) begin
      mdl_pulse = 1'b0;
      if (hh <= 23 && mm <= 59 && ss <= 59) begin
        mdl_t = hh * 3600 + mm * 60 + ss;
        mdl_p = 0;
        mdl_err = 1'b0;
      end else begin
        mdl_err = 1'b1;
      end
    end else if (r) begin
      mdl_err = 1'b0;
      if (mdl_p == int'(SEC_DIV) - 1) begin
        mdl_p = 0;
        mdl_t = (mdl_t + 1) % DAY_SECS;
        mdl_pulse = 1'b1;
      end else begin
        mdl_p = mdl_p + 1;
        mdl_pulse = 1'b0;
      end
    end else begin
      mdl_pulse = 1'b0;
      mdl_err = 1'b0;
    end
  endtask

  // Scoreboard compare.
  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual{h12,pm,m,s,pulse,err}=%0d,%0d,%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d,%0d,%0d",
               name, act[18:15], act[14], act[13:8], act[7:2], act[1], act[0],
               exp[18:15], exp[14], exp[13:8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  // Driver: one clock with the given inputs, then compare against the model.
  task automatic step(input logic r, input logic l, input int hh, input int mm, input int ss);
    run    = r;
    load   = l;
    ld_h24 = 5'(hh);
    ld_m   = 6'(mm);
    ld_s   = 6'(ss);
    @(posedge clk);
    #1;
    model_step(r, l, hh, mm, ss);
    check("model", dut_out, model_out());
    load = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        l;
    int          hh;
    int          mm;
    int          ss;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 1'b1,  0,  0,  0, pk(12, 0,  0,  0, 0, 0)};
    tbl[1] = '{1'b0, 1'b1, 11, 59, 59, pk(11, 0, 59, 59, 0, 0)};
    tbl[2] = '{1'b0, 1'b1, 12,  0,  0, pk(12, 1,  0,  0, 0, 0)};
    tbl[3] = '{1'b0, 1'b1, 13,  5,  7, pk( 1, 1,  5,  7, 0, 0)};
    tbl[4] = '{1'b0, 1'b1, 24,  0,  0, pk( 1, 1,  5,  7, 0, 1)};
    tbl[5] = '{1'b0, 1'b1,  5, 60,  0, pk( 1, 1,  5,  7, 0, 1)};
    tbl[6] = '{1'b0, 1'b1,  5,  0, 63, pk( 1, 1,  5,  7, 0, 1)};
    tbl[7] = '{1'b0, 1'b1, 23, 59, 59, pk(11, 1, 59, 59, 0, 0)};
    tbl[8] = '{1'b0, 1'b0,  0,  0,  0, pk(11, 1, 59, 59, 0, 0)};
    tbl[9] = '{1'b0, 1'b1,  1,  2,  3, pk( 1, 0,  2,  3, 0, 0)};

    // Power-on reset.
    #3;
    check("reset_init", dut_out, pk(12, 0, 0, 0, 0, 0));
    #9 rst_n = 1'b1;
    model_reset();

    // Decode corners and invalid loads.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].hh, tbl[i].mm, tbl[i].ss);
      check($sformatf("table_%0d", i), dut_out, tbl[i].exp);
    end

    // Wrap across midnight.
    step(1'b1, 1'b1, 23, 59, 58);
    repeat (3) step(1'b1, 1'b0, 0, 0, 0);
    check("wrap_before", dut_out, pk(11, 1, 59, 58, 0, 0));
    step(1'b1, 1'b0, 0, 0, 0);
    check("wrap_2359_59", dut_out, pk(11, 1, 59, 59, 1, 0));
    repeat (3) step(1'b1, 1'b0, 0, 0, 0);
    check("wrap_hold", dut_out, pk(11, 1, 59, 59, 0, 0));
    step(1'b1, 1'b0, 0, 0, 0);
    check("wrap_midnight", dut_out, pk(12, 0, 0, 0, 1, 0));

    // 11:59:59 am plus one tick becomes noon.
    step(1'b1, 1'b1, 11, 59, 59);
    repeat (4) step(1'b1, 1'b0, 0, 0, 0);
    check("noon", dut_out, pk(12, 1, 0, 0, 1, 0));

    // Load colliding with a tick.
    step(1'b1, 1'b1, 8, 0, 0);
    repeat (3) step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 10, 20, 30);
    check("collide_load", dut_out, pk(10, 0, 20, 30, 0, 0));
    repeat (3) step(1'b1, 1'b0, 0, 0, 0);
    check("collide_wait", dut_out, pk(10, 0, 20, 30, 0, 0));
    step(1'b1, 1'b0, 0, 0, 0);
    check("collide_tick", dut_out, pk(10, 0, 20, 31, 1, 0));

    // Rejected load keeps the prescaler phase.
    step(1'b1, 1'b1, 3, 0, 0);
    repeat (2) step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 24, 0, 0);
    check("bad_load", dut_out, pk(3, 0, 0, 0, 0, 1));
    step(1'b1, 1'b0, 0, 0, 0);
    check("bad_load_clear", dut_out, pk(3, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, 0, 0, 0);
    check("bad_load_tick", dut_out, pk(3, 0, 0, 1, 1, 0));

    // Freeze mid-count for 7 clocks, then resume from the same phase.
    step(1'b1, 1'b1, 6, 30, 0);
    repeat (2) step(1'b1, 1'b0, 0, 0, 0);
    repeat (7) step(1'b0, 1'b0, 0, 0, 0);
    check("frozen", dut_out, pk(6, 0, 30, 0, 0, 0));
    step(1'b1, 1'b0, 0, 0, 0);
    check("resume_p3", dut_out, pk(6, 0, 30, 0, 0, 0));
    step(1'b1, 1'b0, 0, 0, 0);
    check("resume_tick", dut_out, pk(6, 0, 30, 1, 1, 0));

    // Asynchronous reset in the middle of a cycle.
    step(1'b1, 1'b1, 15, 45, 10);
    repeat (2) step(1'b1, 1'b0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("reset_mid", dut_out, pk(12, 0, 0, 0, 0, 0));
    model_reset();
    #2 rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 0, 0, 0);
    check("after_reset_tick", dut_out, pk(12, 0, 0, 1, 1, 0));

    // Randomized sweep, biased toward carry boundaries and out-of-range fields.
    for (int i = 0; i < 1000; i++) begin
      logic r;
      logic l;
      int   hh;
      int   mm;
      int   ss;
      r  = ($urandom_range(0, 7) != 0);
      l  = ($urandom_range(0, 5) == 0);
      hh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(10, 23));
      mm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(57, 59));
      ss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(55, 59));
      step(r, l, hh, mm, ss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
